// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP layer sequencer: default sizes, class index width, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mlp_pkg;

    localparam int DEF_NUM_HIDDEN     = 10;
    localparam int DEF_NUM_OUTPUT     = 10;
    localparam int DEF_DATA_W         = 16;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    // Width of the winning-class index for the default output layer size.
    localparam int CLASS_W = $clog2(DEF_NUM_OUTPUT);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_H,
        WAIT_H,
        ISSUE_O,
        WAIT_O,
        ARGMAX,
        DONE
    } seq_state_t;

endpackage

// File: rtl/argmax_scan.sv
// Captures output-layer ReLU results and scans them one element per cycle for the maximum.
// Latency: N cycles of scan_start; scan_done marks the last element, res_* then hold the final winner.
// Backpressure: none; captures are taken whenever cap_en and the per-element valid are high.
//
// Ports:
//   clk, reset          - clock, async active-high reset
//   cap_en/cap_vld/cap_dat - capture window, per-element strobe and data
//   scan_start          - held high for exactly N cycles to run the scan
//   scan_done           - high on the cycle that processes element N-1
//   res_idx/res_val     - running max including the element being scanned this cycle
module argmax_scan
    import mlp_pkg::*;
#(
    parameter int N      = DEF_NUM_OUTPUT,
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W  = CLASS_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cap_en,
    input  logic [N-1:0]               cap_vld,
    input  logic [N-1:0][DATA_W-1:0]   cap_dat,
    input  logic                       scan_start,
    output logic                       scan_done,
    output logic [IDX_W-1:0]           res_idx,
    output logic [DATA_W-1:0]          res_val
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    logic [N-1:0][DATA_W-1:0] cap_q, cap_d;
    logic [IDX_W-1:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]         best_idx_q, best_idx_d;
    logic [DATA_W-1:0]        best_val_q, best_val_d;
    logic [DATA_W-1:0]        cur_val;

    always_comb begin
        cap_d = cap_q;
        for (int i = 0; i < N; i++) begin
            if (cap_en && cap_vld[i]) begin
                cap_d[i] = cap_dat[i];
            end
        end

        cur_val = cap_q[cnt_q];

        // Element 0 seeds the running max; later elements must be strictly
        // greater to win, so ties keep the lower index.
        if ((cnt_q == '0) || (cur_val > best_val_q)) begin
            res_idx = cnt_q;
            res_val = cur_val;
        end else begin
            res_idx = best_idx_q;
            res_val = best_val_q;
        end

        scan_done  = scan_start && (cnt_q == LAST);
        cnt_d      = (scan_start && !scan_done) ? cnt_q + IDX_W'(1) : '0;
        best_idx_d = scan_start ? res_idx : best_idx_q;
        best_val_d = scan_start ? res_val : best_val_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_q      <= '0;
            cnt_q      <= '0;
            best_idx_q <= '0;
            best_val_q <= '0;
        end else begin
            cap_q      <= cap_d;
            cnt_q      <= cnt_d;
            best_idx_q <= best_idx_d;
            best_val_q <= best_val_d;
        end
    end

endmodule

// File: rtl/mlp_layer_sequencer.sv
// Sequences one two-layer MLP inference: hidden MAC issue, output MAC issue, argmax, done pulse.
// Latency: done at 3+Kh+Ko+NUM_OUTPUT cycles after start (Kh/Ko = layer return delays).
// Backpressure: start only accepted in IDLE and never queued; WAIT states hold until all valids seen.
//
// Ports: clk, reset (async active-high), start, busy, done, error,
//   hidden_mac_valid/hidden_relu_valid, output_mac_valid/output_relu_valid/output_relu_out,
//   class_idx/class_val (winner, held until the next successful done).
// Optional macro SEQ_TIMEOUT_EN adds a per-wait-phase watchdog that ends the
// inference with done+error after TIMEOUT_CYCLES cycles of an incomplete mask.
module mlp_layer_sequencer
    import mlp_pkg::*;
#(
    parameter int NUM_HIDDEN     = DEF_NUM_HIDDEN,
    parameter int NUM_OUTPUT     = DEF_NUM_OUTPUT,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    output logic                                error,
    output logic [NUM_HIDDEN-1:0]               hidden_mac_valid,
    input  logic [NUM_HIDDEN-1:0]               hidden_relu_valid,
    output logic [NUM_OUTPUT-1:0]               output_mac_valid,
    input  logic [NUM_OUTPUT-1:0]               output_relu_valid,
    input  logic [NUM_OUTPUT-1:0][DATA_W-1:0]   output_relu_out,
    output logic [$clog2(NUM_OUTPUT)-1:0]       class_idx,
    output logic [DATA_W-1:0]                   class_val
);

    localparam int IDX_W = $clog2(NUM_OUTPUT);

    seq_state_t              state_q, state_d;
    logic [NUM_HIDDEN-1:0]   hmask_q, hmask_d;
    logic [NUM_OUTPUT-1:0]   omask_q, omask_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic [NUM_HIDDEN-1:0]   hmv_q, hmv_d;
    logic [NUM_OUTPUT-1:0]   omv_q, omv_d;
    logic [IDX_W-1:0]        class_idx_q, class_idx_d;
    logic [DATA_W-1:0]       class_val_q, class_val_d;

    logic                    timeout;
    logic                    scan_done;
    logic [IDX_W-1:0]        scan_idx;
    logic [DATA_W-1:0]       scan_val;

`ifdef SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wdog_q, wdog_d;

    // Counter is zero in the first cycle of each WAIT state; timeout fires in
    // the WAIT cycle whose increment reaches the limit.
    always_comb begin
        wdog_d  = '0;
        timeout = 1'b0;
        if ((state_q == WAIT_H) || (state_q == WAIT_O)) begin
            wdog_d  = wdog_q + WD_W'(1);
            timeout = (wdog_d == WD_W'(TIMEOUT_CYCLES));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

    argmax_scan #(
        .N      (NUM_OUTPUT),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_argmax (
        .clk        (clk),
        .reset      (reset),
        .cap_en     (state_q == WAIT_O),
        .cap_vld    (output_relu_valid),
        .cap_dat    (output_relu_out),
        .scan_start (state_q == ARGMAX),
        .scan_done  (scan_done),
        .res_idx    (scan_idx),
        .res_val    (scan_val)
    );

    always_comb begin
        state_d     = state_q;
        hmask_d     = hmask_q;
        omask_d     = omask_q;
        error_d     = 1'b0;
        class_idx_d = class_idx_q;
        class_val_d = class_val_q;

        case (state_q)
            IDLE: begin
                if (start) state_d = ISSUE_H;
            end
            ISSUE_H: begin
                hmask_d = '0;
                state_d = WAIT_H;
            end
            WAIT_H: begin
                // Completion includes this cycle's valids so the next layer
                // issues the cycle after the last return.
                hmask_d = hmask_q | hidden_relu_valid;
                if (&hmask_d) begin
                    state_d = ISSUE_O;
                end else if (timeout) begin
                    state_d = DONE;
                    error_d = 1'b1;
                end
            end
            ISSUE_O: begin
                omask_d = '0;
                state_d = WAIT_O;
            end
            WAIT_O: begin
                omask_d = omask_q | output_relu_valid;
                if (&omask_d) begin
                    state_d = ARGMAX;
                end else if (timeout) begin
                    state_d = DONE;
                    error_d = 1'b1;
                end
            end
            ARGMAX: begin
                if (scan_done) begin
                    state_d     = DONE;
                    class_idx_d = scan_idx;
                    class_val_d = scan_val;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // All outputs are registered copies of the decoded next state.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        hmv_d  = {NUM_HIDDEN{state_d == ISSUE_H}};
        omv_d  = {NUM_OUTPUT{state_d == ISSUE_O}};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            hmask_q     <= '0;
            omask_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            hmv_q       <= '0;
            omv_q       <= '0;
            class_idx_q <= '0;
            class_val_q <= '0;
        end else begin
            state_q     <= state_d;
            hmask_q     <= hmask_d;
            omask_q     <= omask_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            hmv_q       <= hmv_d;
            omv_q       <= omv_d;
            class_idx_q <= class_idx_d;
            class_val_q <= class_val_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign error            = error_q;
    assign hidden_mac_valid = hmv_q;
    assign output_mac_valid = omv_q;
    assign class_idx        = class_idx_q;
    assign class_val        = class_val_q;

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Self-checking bench for mlp_layer_sequencer against a cycle-schedule reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_mlp_layer_sequencer;

    localparam int NH = 10;
    localparam int NO = 10;
    localparam int DW = 16;
    localparam int TO = 255;
    localparam int IW = 4;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  start = 1'b0;
    logic [NH-1:0]         hidden_relu_valid = '0;
    logic [NO-1:0]         output_relu_valid = '0;
    logic [NO-1:0][DW-1:0] output_relu_out = '0;
    logic                  busy, done, error;
    logic [NH-1:0]         hidden_mac_valid;
    logic [NO-1:0]         output_mac_valid;
    logic [IW-1:0]         class_idx;
    logic [DW-1:0]         class_val;

    int            checks = 0;
    int            errors = 0;
    logic [IW-1:0] exp_idx = '0;
    logic [DW-1:0] exp_val = '0;

    mlp_layer_sequencer #(
        .NUM_HIDDEN     (NH),
        .NUM_OUTPUT     (NO),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .busy              (busy),
        .done              (done),
        .error             (error),
        .hidden_mac_valid  (hidden_mac_valid),
        .hidden_relu_valid (hidden_relu_valid),
        .output_mac_valid  (output_mac_valid),
        .output_relu_valid (output_relu_valid),
        .output_relu_out   (output_relu_out),
        .class_idx         (class_idx),
        .class_val         (class_val)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "time limit");
    end

    // Reference winner: the largest value, then the first index holding it.
    function automatic void ref_argmax(input logic [DW-1:0] v[NO], output int idx, output logic [DW-1:0] mx);
        mx  = '0;
        idx = -1;
        for (int i = 0; i < NO; i++) if (v[i] > mx) mx = v[i];
        for (int i = 0; i < NO; i++) if (idx < 0 && v[i] == mx) idx = i;
    endfunction

    // Drives one inference from IDLE. Hidden bit i returns h[i] cycles after
    // the hidden issue, output bit i o[i] cycles after the output issue.
    // Expected schedule: issue_o = 2+Kh, done = 3+Kh+Ko+NO.
    task automatic run_inf(input string name, input int h[NH], input int o[NO], input logic [DW-1:0] v[NO],
                           input bit hold, input bit noisy, input int rep);
        int kh, ko, t_omv, t_done, last_c, ridx;
        logic [DW-1:0] rval;
        logic e_busy, e_done;
        logic [NH-1:0] e_hmv;
        logic [NO-1:0] e_omv;
        kh = 0;
        ko = 0;
        for (int i = 0; i < NH; i++) if (h[i] > kh) kh = h[i];
        for (int i = 0; i < NO; i++) if (o[i] > ko) ko = o[i];
        t_omv  = 2 + kh;
        t_done = 3 + kh + ko + NO;
        last_c = hold ? t_done + 2 : t_done + 1;
        ref_argmax(v, ridx, rval);
        for (int c = 0; c <= last_c; c++) begin
            start = (c == 0) || hold;
            hidden_relu_valid = '0;
            output_relu_valid = '0;
            for (int i = 0; i < NH; i++) begin
                if (c == 1 + h[i] || (i == rep && c == 2 + h[i])) hidden_relu_valid[i] = 1'b1;
                else if (noisy && (c <= 1 || c > 1 + h[i]) && $urandom_range(0, 3) == 0) hidden_relu_valid[i] = 1'b1;
            end
            for (int i = 0; i < NO; i++) begin
                output_relu_out[i] = DW'($urandom);
                if (c == 2 + kh + o[i]) begin
                    output_relu_valid[i] = 1'b1;
                    output_relu_out[i]   = v[i];
                end else if (noisy && $urandom_range(0, 3) == 0) begin
                    if (c <= 2 + kh) begin
                        output_relu_valid[i] = 1'b1;
                    end else if (c > 2 + kh + o[i]) begin
                        output_relu_valid[i] = 1'b1;
                        if (c <= 2 + kh + ko) output_relu_out[i] = v[i];
                    end
                end
            end
            @(negedge clk);
            e_busy = (c >= 1 && c <= t_done) || (hold && c == t_done + 2);
            e_hmv  = (c == 1 || (hold && c == t_done + 2)) ? '1 : '0;
            e_omv  = (c == t_omv) ? '1 : '0;
            e_done = (c == t_done);
            if (c == t_done) begin
                exp_idx = IW'(ridx);
                exp_val = rval;
            end
            checks++;
            if (busy !== e_busy) begin errors++; $display("FAIL %s busy c=%0d got %b exp %b", name, c, busy, e_busy); end
            checks++;
            if (hidden_mac_valid !== e_hmv) begin errors++; $display("FAIL %s hidden_mac_valid c=%0d got %h exp %h", name, c, hidden_mac_valid, e_hmv); end
            checks++;
            if (output_mac_valid !== e_omv) begin errors++; $display("FAIL %s output_mac_valid c=%0d got %h exp %h", name, c, output_mac_valid, e_omv); end
            checks++;
            if (done !== e_done) begin errors++; $display("FAIL %s done c=%0d got %b exp %b", name, c, done, e_done); end
            checks++;
            if (error !== 1'b0) begin errors++; $display("FAIL %s error c=%0d got %b exp 0", name, c, error); end
            checks++;
            if (class_idx !== exp_idx || class_val !== exp_val) begin
                errors++;
                $display("FAIL %s class c=%0d got %0d/%0d exp %0d/%0d", name, c, class_idx, class_val, exp_idx, exp_val);
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        hidden_relu_valid = '0;
        output_relu_valid = '0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl got busy=%b done=%b error=%b exp 0", busy, done, error);
        end
        checks++;
        if (hidden_mac_valid !== '0 || output_mac_valid !== '0) begin
            errors++; $display("FAIL reset_mac got %h/%h exp 0", hidden_mac_valid, output_mac_valid);
        end
        checks++;
        if (class_idx !== '0 || class_val !== '0) begin
            errors++; $display("FAIL reset_class got %0d/%0d exp 0", class_idx, class_val);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        int h[NH]; int o[NO]; logic [DW-1:0] v[NO];
        foreach (h[i]) h[i] = 1;
        foreach (o[i]) o[i] = 2;
        v = '{16'd5, 16'd9, 16'd3, 16'd9, 16'd0, 16'd1, 16'd2, 16'd8, 16'd7, 16'd6};
        run_inf("basic", h, o, v, 1'b0, 1'b0, -1);
    endtask

    task automatic test_all_zero;
        int h[NH]; int o[NO]; logic [DW-1:0] v[NO];
        foreach (h[i]) h[i] = 2;
        foreach (o[i]) o[i] = 1;
        foreach (v[i]) v[i] = '0;
        run_inf("all_zero", h, o, v, 1'b0, 1'b1, -1);
    endtask

    task automatic test_staggered;
        int h[NH]; int o[NO]; logic [DW-1:0] v[NO];
        foreach (h[i]) h[i] = i + 1;
        foreach (o[i]) o[i] = NO - i;
        v = '{16'd3, 16'd1, 16'd4, 16'd1, 16'd5, 16'd9, 16'd2, 16'd6, 16'd5, 16'd3};
        run_inf("staggered", h, o, v, 1'b0, 1'b0, 4);
    endtask

    task automatic test_reset_mid;
        int h[NH]; int o[NO]; logic [DW-1:0] v[NO];
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        hidden_relu_valid = '1;
        @(posedge clk); #1;
        hidden_relu_valid = '0;
        @(posedge clk); #1;
        output_relu_valid = 10'h00F;
        foreach (output_relu_out[i]) output_relu_out[i] = DW'(100 + i);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL reset_mid pre_busy got %b exp 1", busy); end
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        exp_idx = '0;
        exp_val = '0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            errors++; $display("FAIL reset_mid ctrl got busy=%b done=%b error=%b exp 0", busy, done, error);
        end
        checks++;
        if (hidden_mac_valid !== '0 || output_mac_valid !== '0) begin
            errors++; $display("FAIL reset_mid mac got %h/%h exp 0", hidden_mac_valid, output_mac_valid);
        end
        checks++;
        if (class_idx !== exp_idx || class_val !== exp_val) begin
            errors++; $display("FAIL reset_mid class got %0d/%0d exp 0", class_idx, class_val);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        output_relu_valid = '0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_mid after got busy=%b done=%b exp 0", busy, done);
        end
        @(posedge clk); #1;
        foreach (h[i]) h[i] = $urandom_range(1, 4);
        foreach (o[i]) o[i] = $urandom_range(1, 4);
        foreach (v[i]) v[i] = DW'($urandom);
        run_inf("after_reset", h, o, v, 1'b0, 1'b0, -1);
    endtask

    task automatic test_random;
        int h[NH]; int o[NO]; logic [DW-1:0] v[NO];
        for (int n = 0; n < 25; n++) begin
            foreach (h[i]) h[i] = $urandom_range(1, 6);
            foreach (o[i]) o[i] = $urandom_range(1, 6);
            foreach (v[i]) v[i] = (n % 3 == 0) ? DW'($urandom_range(0, 3)) : DW'($urandom);
            run_inf("random", h, o, v, 1'b0, 1'b1, -1);
        end
    endtask

`ifdef SEQ_TIMEOUT_EN
    task automatic test_timeout;
        logic e_end;
        for (int c = 0; c <= TO + 4; c++) begin
            start = (c == 0);
            hidden_relu_valid = (c == 2) ? 10'h37F : 10'h000;
            @(negedge clk);
            e_end = (c == 2 + TO);
            checks++;
            if (done !== e_end || error !== e_end) begin
                errors++; $display("FAIL timeout done_error c=%0d got %b/%b exp %b", c, done, error, e_end);
            end
            checks++;
            if (busy !== (c >= 1 && c <= 2 + TO)) begin
                errors++; $display("FAIL timeout busy c=%0d got %b", c, busy);
            end
            checks++;
            if (class_idx !== exp_idx || class_val !== exp_val) begin
                errors++; $display("FAIL timeout class c=%0d got %0d/%0d exp %0d/%0d", c, class_idx, class_val, exp_idx, exp_val);
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        hidden_relu_valid = '0;
    endtask
`endif

    task automatic test_hold_start;
        int h[NH]; int o[NO]; logic [DW-1:0] v[NO];
        foreach (h[i]) h[i] = $urandom_range(1, 3);
        foreach (o[i]) o[i] = $urandom_range(1, 3);
        foreach (v[i]) v[i] = DW'($urandom);
        run_inf("hold_start", h, o, v, 1'b1, 1'b0, -1);
        reset = 1'b1;
        exp_idx = '0;
        exp_val = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_zero();
        test_staggered();
        test_reset_mid();
        test_random();
`ifdef SEQ_TIMEOUT_EN
        test_timeout();
`endif
        test_hold_start();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
